alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Multi-cycle, width-parametrised RV integer ALU with valid/ready handshake on both sides.
//  Executes RV32I/RV64I ALU ops in 1 cycle; optionally executes M-extension mul/div
//  iteratively (1 bit per cycle). Sits in the EX stage between decode and writeback.
//  The pipeline stalls on in_ready=0.
// PARAMETERS
//  XLEN     32                 operand/result width (32 or 64)
//  SHAMT_W  $clog2(XLEN)       shift-amount bits taken from op_b[SHAMT_W-1:0]
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     op_a/op_b/func3/func/muldiv valid
//  in_ready   out  1     ALU can accept an op (=1 only in IDLE)
//  func3      in   3     RV funct3
//  func       in   1     funct7[5]: sub / sra select
//  muldiv     in   1     funct7[0]: M-extension op
//  op_a       in   XLEN  rs1 / operand A
//  op_b       in   XLEN  rs2 or immediate / operand B
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  registered result
//  overflow   out  1     signed overflow of add/sub; 0 for all other ops
//  illegal    out  1     unsupported {func,muldiv,func3} combination
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, illegal=0, counters=0.
//  Reset mid-operation aborts the op; no result is ever presented for it.
//  FSM: IDLE -(in_valid & base op)-> DONE; IDLE -(in_valid & muldiv)-> BUSY;
//       BUSY -(cnt==XLEN-1)-> DONE; DONE -(out_ready)-> IDLE.
//  Accept = in_valid & in_ready; operands are latched at accept, later input changes are ignored.
//  Base ops: result/out_valid registered on the accepting edge, so out_valid rises 1 cycle after accept.
//   000 add (func=0) / sub (func=1);  001 sll;  010 slt (signed);  011 sltu;
//   100 xor;  101 srl (func=0) / sra (func=1);  110 or;  111 and.
//  func=1 is legal only with 000 and 101. Any other func=1 op: result=0, illegal=1.
//  Arithmetic is modulo 2^XLEN. overflow = (a_s==b'_s)&(r_s!=a_s), where b' = ~b for sub.
//  M ops (func3): 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
//   Multiply: shift-add over magnitudes, 2*XLEN product, sign fixed at end.
//   Divide: restoring, magnitudes, sign fixed at end.
//   out_valid rises exactly XLEN+1 cycles after accept.
//  Divide by zero: div/divu quotient = all-ones; rem/remu = op_a. No stall, no flag.
//  Signed overflow (op_a=-2^(XLEN-1), op_b=-1): div = op_a; rem = 0.
//  Back-pressure: while out_valid & !out_ready, result/overflow/illegal stay stable.
//   In that state in_ready=0.
//  Back-to-back throughput for base ops is 1 op per 2 cycles (IDLE->DONE->IDLE).
// CONFIGURATION
//  ALU_MULDIV_EN defined: M ops execute as above.
//  ALU_MULDIV_EN undefined: BUSY state and mul/div datapath are not compiled. Any accept with
//   muldiv=1 completes with base latency: result=0, illegal=1, overflow=0.
// TESTING
//  1. rst held 2 cycles, then released -> in_ready=1, out_valid=0, result=0 on first cycle after.
//  2. XLEN=32: add 0x7FFFFFFF+1 -> result 0x80000000, overflow=1.
//     sub 0-1 -> 0xFFFFFFFF, overflow=0; out_valid 1 cycle after accept.
//  3. sra 0x80000000 by op_b=0x24 (shamt 4) -> 0xF8000000.
//     srl -> 0x08000000. slt -1,1 -> 1; sltu -1,1 -> 0.
//  4. MULDIV_EN: mulh 0xFFFFFFFF*0xFFFFFFFF -> 0 (mul -> 1).
//     mulhu -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
//  5. div 7/0 -> 0xFFFFFFFF; rem 7/0 -> 7.
//     div 0x80000000/-1 -> 0x80000000; rem -> 0. div -7/2 -> -3; rem -> -1.
//  6. out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0.
//     Assert rst during a BUSY divide -> next cycle IDLE, out_valid never rises for that op.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV integer ALU with valid/ready on both sides.
// Base ops complete on the accepting edge. M-extension ops run one bit per cycle.
// Optional feature macro: ALU_MULDIV_EN.
//   Defined:   mul/div datapath and BUSY state are built.
//   Undefined: any muldiv op completes at base latency with illegal=1.
module alu_mc #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      func3,
   input  logic            func,
   input  logic            muldiv,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            overflow,
   output logic            illegal
);

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
   localparam int CNT_W = $clog2(XLEN);
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`endif

   state_t              state_r, state_s;
   logic                in_ready_r, out_valid_r, overflow_r, illegal_r;
   logic [XLEN-1:0]     result_r;
   logic                load_s, load_ovf_s, load_ill_s;
   logic [XLEN-1:0]     load_res_s;
   logic [XLEN-1:0]     base_res_s, add_s, sub_s;
   logic                base_ovf_s, base_ill_s;
   logic [SHAMT_W-1:0]  shamt_s;

   assign add_s   = op_a + op_b;
   assign sub_s   = op_a - op_b;
   assign shamt_s = op_b[SHAMT_W-1:0];

`ifdef ALU_MULDIV_EN
   logic [CNT_W-1:0]    cnt_r;
   logic [XLEN-1:0]     hi_r, lo_r, mb_r, a_r;
   logic [2:0]          f3_r;
   logic                sa_r, sb_r, start_s, sa_s, sb_s, div_ge_s;
   logic [XLEN-1:0]     mag_a_s, mag_b_s, hi_n_s, lo_n_s, div_diff_s, md_res_s;
   logic [XLEN:0]       mul_sum_s, div_sh_s;
   logic [2*XLEN-1:0]   md_prod_s;

   // Operand signedness and magnitudes for the mul/div op being accepted
   always_comb begin
      if (func3[2]) begin
         sa_s = ~func3[0] & op_a[XLEN-1];
         sb_s = ~func3[0] & op_b[XLEN-1];
      end else begin
         sa_s = ((func3[1:0] == 2'b01) || (func3[1:0] == 2'b10)) & op_a[XLEN-1];
         sb_s = (func3[1:0] == 2'b01) & op_b[XLEN-1];
      end
      mag_a_s = sa_s ? (-op_a) : op_a;
      mag_b_s = sb_s ? (-op_b) : op_b;
   end

   // One shift-add or restoring-divide step plus the sign-fixed final result
   always_comb begin
      mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mb_r} : {(XLEN+1){1'b0}});
      div_sh_s   = {hi_r, lo_r[XLEN-1]};
      div_ge_s   = (div_sh_s >= {1'b0, mb_r});
      div_diff_s = div_sh_s[XLEN-1:0] - mb_r;
      if (f3_r[2]) begin
         hi_n_s = div_ge_s ? div_diff_s : div_sh_s[XLEN-1:0];
         lo_n_s = {lo_r[XLEN-2:0], div_ge_s};
      end else begin
         hi_n_s = mul_sum_s[XLEN:1];
         lo_n_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
      end
      md_prod_s = (sa_r ^ sb_r) ? (-{hi_n_s, lo_n_s}) : {hi_n_s, lo_n_s};
      case (f3_r)
         3'b000:                 md_res_s = md_prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: md_res_s = md_prod_s[2*XLEN-1:XLEN];
         3'b100:  md_res_s = (mb_r == '0) ? {XLEN{1'b1}} : ((sa_r ^ sb_r) ? (-lo_n_s) : lo_n_s);
         3'b101:  md_res_s = (mb_r == '0) ? {XLEN{1'b1}} : lo_n_s;
         3'b110:  md_res_s = (mb_r == '0) ? a_r : (sa_r ? (-hi_n_s) : hi_n_s);
         3'b111:  md_res_s = (mb_r == '0) ? a_r : hi_n_s;
         default: md_res_s = '0;
      endcase
   end

   // Iterative mul/div state: load magnitudes on accept, step once per BUSY cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
         hi_r  <= '0;
         lo_r  <= '0;
         mb_r  <= '0;
         a_r   <= '0;
         f3_r  <= 3'b000;
         sa_r  <= 1'b0;
         sb_r  <= 1'b0;
      end else if (start_s) begin
         cnt_r <= '0;
         hi_r  <= '0;
         lo_r  <= mag_a_s;
         mb_r  <= mag_b_s;
         a_r   <= op_a;
         f3_r  <= func3;
         sa_r  <= sa_s;
         sb_r  <= sb_s;
      end else if (state_r == ST_BUSY) begin
         cnt_r <= cnt_r + CNT_W'(1);
         hi_r  <= hi_n_s;
         lo_r  <= lo_n_s;
      end
   end
`endif

   // Single-cycle base op result, overflow and legality for the presented operands
   always_comb begin
      base_res_s = '0;
      base_ovf_s = 1'b0;
      base_ill_s = 1'b0;
      if (func && (func3 != 3'b000) && (func3 != 3'b101)) begin
         base_ill_s = 1'b1;
      end else begin
         case (func3)
            3'b000: begin
               if (func) begin
                  base_res_s = sub_s;
                  base_ovf_s = (op_a[XLEN-1] == ~op_b[XLEN-1]) && (sub_s[XLEN-1] != op_a[XLEN-1]);
               end else begin
                  base_res_s = add_s;
                  base_ovf_s = (op_a[XLEN-1] == op_b[XLEN-1]) && (add_s[XLEN-1] != op_a[XLEN-1]);
               end
            end
            3'b001:  base_res_s = op_a << shamt_s;
            3'b010:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011:  base_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100:  base_res_s = op_a ^ op_b;
            3'b101: begin
               if (func) begin
                  base_res_s = $unsigned($signed(op_a) >>> shamt_s);
               end else begin
                  base_res_s = op_a >> shamt_s;
               end
            end
            3'b110:  base_res_s = op_a | op_b;
            3'b111:  base_res_s = op_a & op_b;
            default: base_ill_s = 1'b1;
         endcase
      end
   end

   // Next state and the value to capture into the output registers
   always_comb begin
      state_s    = state_r;
      load_s     = 1'b0;
      load_res_s = base_res_s;
      load_ovf_s = base_ovf_s;
      load_ill_s = base_ill_s;
`ifdef ALU_MULDIV_EN
      start_s    = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               if (muldiv) begin
`ifdef ALU_MULDIV_EN
                  if (func) begin
                     state_s    = ST_DONE;
                     load_s     = 1'b1;
                     load_res_s = '0;
                     load_ovf_s = 1'b0;
                     load_ill_s = 1'b1;
                  end else begin
                     state_s = ST_BUSY;
                     start_s = 1'b1;
                  end
`else
                  state_s    = ST_DONE;
                  load_s     = 1'b1;
                  load_res_s = '0;
                  load_ovf_s = 1'b0;
                  load_ill_s = 1'b1;
`endif
               end else begin
                  state_s = ST_DONE;
                  load_s  = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
`ifdef ALU_MULDIV_EN
         ST_BUSY: begin
            if (cnt_r == CNT_W'(XLEN-1)) begin
               state_s    = ST_DONE;
               load_s     = 1'b1;
               load_res_s = md_res_s;
               load_ovf_s = 1'b0;
               load_ill_s = 1'b0;
            end else begin
               state_s = ST_BUSY;
            end
         end
`endif
         ST_DONE: begin
            if (out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register and registered handshake/result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= '0;
         overflow_r  <= 1'b0;
         illegal_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == ST_IDLE);
         out_valid_r <= (state_s == ST_DONE);
         if (load_s) begin
            result_r   <= load_res_s;
            overflow_r <= load_ovf_s;
            illegal_r  <= load_ill_s;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign overflow  = overflow_r;
   assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed self-checking bench for alu_mc (XLEN=32).
`timescale 1ns/1ps
module tb_alu_mc;
   localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0, func = 1'b0, muldiv = 1'b0, out_ready = 1'b0;
   logic [2:0]      func3 = 3'd0;
   logic [XLEN-1:0] op_a = '0, op_b = '0;
   logic            in_ready, out_valid, overflow, illegal;
   logic [XLEN-1:0] result;

   int              checks = 0, errors = 0;
   int              cyc = 0, acc_cyc = 0, exp_lat = 1;
   logic            pending = 1'b0, prev_ov = 1'b0;
   logic [XLEN-1:0] exp_res = '0;
   logic            exp_ovf = 1'b0, exp_ill = 1'b0;

   alu_mc #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .func3(func3), .func(func), .muldiv(muldiv), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .overflow(overflow), .illegal(illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: {illegal, overflow, result} from the ISA rules using 64-bit arithmetic
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic fn,
                                         input logic md, input logic en);
      longint sa, sb, ua, ub, s;
      logic [63:0] p;
      logic [31:0] r;
      logic ov, il;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      r = 32'd0; ov = 1'b0; il = 1'b0; p = 64'd0; s = 64'sd0;
      if (md) begin
         if (!en || fn) il = 1'b1;
         else begin
            case (f3)
               3'd0: begin p = ua * ub; r = p[31:0]; end
               3'd1: begin p = sa * sb; r = p[63:32]; end
               3'd2: begin p = sa * ub; r = p[63:32]; end
               3'd3: begin p = ua * ub; r = p[63:32]; end
               3'd4: begin
                  if (b == 32'd0) r = 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                  else begin s = sa / sb; r = s[31:0]; end
               end
               3'd5: begin
                  if (b == 32'd0) r = 32'hFFFF_FFFF;
                  else begin s = ua / ub; r = s[31:0]; end
               end
               3'd6: begin
                  if (b == 32'd0) r = a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                  else begin s = sa % sb; r = s[31:0]; end
               end
               default: begin
                  if (b == 32'd0) r = a;
                  else begin s = ua % ub; r = s[31:0]; end
               end
            endcase
         end
      end else if (fn && f3 != 3'd0 && f3 != 3'd5) begin
         il = 1'b1;
      end else begin
         case (f3)
            3'd0: begin
               s = fn ? (sa - sb) : (sa + sb);
               r = s[31:0];
               ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: r = a << b[4:0];
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = fn ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
      return {il, ov, r};
   endfunction

   // Compare process: every cycle with a result presented or an op in flight
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            chk("spurious_out_valid", {63'd0, pending}, 64'd1);
            chk("result", {32'd0, result}, {32'd0, exp_res});
            chk("overflow", {63'd0, overflow}, {63'd0, exp_ovf});
            chk("illegal", {63'd0, illegal}, {63'd0, exp_ill});
            chk("in_ready_while_valid", {63'd0, in_ready}, 64'd0);
            if (!prev_ov) chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
         end else if (pending) begin
            chk("in_ready_in_flight", {63'd0, in_ready}, 64'd0);
            chk("not_late", {63'd0, ((cyc - acc_cyc) < exp_lat)}, 64'd1);
         end
         prev_ov = out_valid;
      end else begin
         prev_ov = 1'b0;
      end
   end

   task automatic set_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          input logic fn, input logic md);
      logic [33:0] m;
      m = model(a, b, f3, fn, md, MD_EN);
      exp_res = m[31:0];
      exp_ovf = m[32];
      exp_ill = m[33];
      exp_lat = (md && MD_EN && !fn) ? XLEN + 1 : 1;
   endtask

   task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic fn, input logic md);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
      set_exp(a, b, f3, fn, md);
      op_a = a; op_b = b; func3 = f3; func = fn; muldiv = md; in_valid = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc - 1;
      pending = 1'b1;
      in_valid = 1'b0;
      op_a = $urandom; op_b = $urandom; func3 = 3'($urandom);
      func = 1'($urandom); muldiv = 1'($urandom);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic fn, input logic md, input int hold);
      int t;
      accept(a, b, f3, fn, md);
      t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < XLEN + 10);
      chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      pending = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic reset_abort(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                              input logic md, input int wait_n);
      accept(a, b, f3, 1'b0, md);
      repeat (wait_n) @(negedge clk);
      rst = 1'b1;
      pending = 1'b0;
      @(posedge clk); #1;
      chk("rst_abort_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_abort_out_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (XLEN + 5) @(negedge clk);
      chk("aborted_never_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic md, fn;
      // Model pins against hand-computed values
      chk("m_add_ovf",  64'(model(32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 1'b1)), {30'd0, 2'b01, 32'h8000_0000});
      chk("m_sub",      64'(model(32'd0, 32'd1, 3'd0, 1'b1, 1'b0, 1'b1)), {32'd0, 32'hFFFF_FFFF});
      chk("m_sra",      64'(model(32'h8000_0000, 32'h24, 3'd5, 1'b1, 1'b0, 1'b1)), {32'd0, 32'hF800_0000});
      chk("m_srl",      64'(model(32'h8000_0000, 32'h24, 3'd5, 1'b0, 1'b0, 1'b1)), {32'd0, 32'h0800_0000});
      chk("m_slt",      64'(model(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 1'b0, 1'b1)), 64'd1);
      chk("m_sltu",     64'(model(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, 1'b0, 1'b1)), 64'd0);
      chk("m_xor_ill",  64'(model(32'd5, 32'd3, 3'd4, 1'b1, 1'b0, 1'b1)), {30'd0, 2'b10, 32'd0});
      chk("m_mulh",     64'(model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0, 1'b1, 1'b1)), 64'd0);
      chk("m_mul",      64'(model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1, 1'b1)), 64'd1);
      chk("m_mulhu",    64'(model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, 1'b1)), {32'd0, 32'hFFFF_FFFE});
      chk("m_div0",     64'(model(32'd7, 32'd0, 3'd4, 1'b0, 1'b1, 1'b1)), {32'd0, 32'hFFFF_FFFF});
      chk("m_rem0",     64'(model(32'd7, 32'd0, 3'd6, 1'b0, 1'b1, 1'b1)), 64'd7);
      chk("m_div_ovf",  64'(model(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b1, 1'b1)), {32'd0, 32'h8000_0000});
      chk("m_rem_ovf",  64'(model(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, 1'b1)), 64'd0);
      chk("m_div_neg",  64'(model(32'hFFFF_FFF9, 32'd2, 3'd4, 1'b0, 1'b1, 1'b1)), {32'd0, 32'hFFFF_FFFD});
      chk("m_rem_neg",  64'(model(32'hFFFF_FFF9, 32'd2, 3'd6, 1'b0, 1'b1, 1'b1)), {32'd0, 32'hFFFF_FFFF});
      chk("m_md_off",   64'(model(32'd7, 32'd3, 3'd4, 1'b0, 1'b1, 1'b0)), {30'd0, 2'b10, 32'd0});

      // Reset held two cycles, then released
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_result", {32'd0, result}, 64'd0);
      chk("reset_overflow", {63'd0, overflow}, 64'd0);
      chk("reset_illegal", {63'd0, illegal}, 64'd0);

      // Directed base and M-extension vectors through the DUT
      run_op(32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 0);
      run_op(32'd0, 32'd1, 3'd0, 1'b1, 1'b0, 0);
      run_op(32'h8000_0000, 32'h24, 3'd5, 1'b1, 1'b0, 1);
      run_op(32'h8000_0000, 32'h24, 3'd5, 1'b0, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, 1'b0, 2);
      run_op(32'h1234_5678, 32'h0F0F_0F0F, 3'd7, 1'b1, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, 0);
      run_op(32'd7, 32'd0, 3'd4, 1'b0, 1'b1, 0);
      run_op(32'd7, 32'd0, 3'd6, 1'b0, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 3'd4, 1'b0, 1'b1, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 3'd6, 1'b0, 1'b1, 5);

      // Reset during a held base result and during a long divide
      reset_abort(32'd9, 32'd4, 3'd0, 1'b0, 3);
      reset_abort(32'd1000, 32'd7, 3'd4, 1'b1, 10);

      // Randomized ops with random back-pressure
      for (int i = 0; i < 150; i++) begin
         md = ($urandom_range(0, 3) == 0);
         fn = md ? 1'b0 : ($urandom_range(0, 3) == 0);
         run_op(pick(), pick(), 3'($urandom), fn, md, $urandom_range(0, 3));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
